// File: rtl/vga_pic_sched_if.sv
// Picture-origin configuration handshake and picture ROM read port of vga_pic_sched.
interface vga_pic_sched_if;
  logic        cfg_valid;
  logic [9:0]  cfg_x;
  logic [9:0]  cfg_y;
  logic        cfg_ready;
  logic        rom_rd_en;
  logic [13:0] rom_addr;
  logic [15:0] rom_data;

  modport master (
    output cfg_valid, cfg_x, cfg_y, rom_data,
    input  cfg_ready, rom_rd_en, rom_addr
  );

  modport slave (
    input  cfg_valid, cfg_x, cfg_y, rom_data,
    output cfg_ready, rom_rd_en, rom_addr
  );
endinterface

// File: rtl/vga_pic_sched.sv
// Places a PIC_W x PIC_H ROM picture at a configurable origin inside the active VGA area;
// origin changes are queued and only take effect at end of frame.
module vga_pic_sched #(
  parameter logic [9:0]  H_VALID  = 10'd640,
  parameter logic [9:0]  V_VALID  = 10'd480,
  parameter logic [9:0]  PIC_W    = 10'd100,
  parameter logic [9:0]  PIC_H    = 10'd100,
  parameter logic [15:0] BG_COLOR = 16'hFFFF
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  vga_pic_sched_if.slave    bus,
  output logic [15:0]       pix_data,
  output logic [7:0]        frame_cnt
);

  localparam logic [9:0]  X_MAX       = H_VALID - PIC_W;
  localparam logic [9:0]  Y_MAX       = V_VALID - PIC_H;
  localparam int          ADDR_LAST_I = int'(PIC_W) * int'(PIC_H) - 1;
  localparam logic [13:0] ADDR_LAST   = ADDR_LAST_I[13:0];

  typedef enum logic {WAIT_SOF = 1'b0, RUN = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [9:0]  org_x_r, org_y_r, pend_x_r, pend_y_r;
  logic        pend_r;
  logic [13:0] rom_addr_r;
  logic        hit_d_r, act_d_r;
  logic [7:0]  frame_cnt_r;
  logic        active_s, eof_s, hit_s, x_in_s, y_in_s, xfer_s;
  logic [9:0]  cap_x_s, cap_y_s;

  assign active_s = (pix_x != 10'h3FF) && (pix_y != 10'h3FF);
  assign eof_s    = active_s && (pix_x == H_VALID - 10'd1) && (pix_y == V_VALID - 10'd1);

  // 11-bit compares so org + size never wraps
  assign x_in_s = ({1'b0, pix_x} >= {1'b0, org_x_r}) &&
                  ({1'b0, pix_x} < ({1'b0, org_x_r} + {1'b0, PIC_W}));
  assign y_in_s = ({1'b0, pix_y} >= {1'b0, org_y_r}) &&
                  ({1'b0, pix_y} < ({1'b0, org_y_r} + {1'b0, PIC_H}));
  assign hit_s  = (state_r == RUN) && active_s && x_in_s && y_in_s;
  assign xfer_s = bus.cfg_valid && !pend_r;

  assign bus.cfg_ready = !pend_r;
  assign bus.rom_rd_en = hit_s;
  assign bus.rom_addr  = rom_addr_r;
  assign frame_cnt     = frame_cnt_r;

  // State register
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_r <= WAIT_SOF;
    else            state_r <= state_s;
  end

  // Next state: the picture is held off until the first complete frame boundary
  always_comb begin
    state_s = state_r;
    case (state_r)
      WAIT_SOF: begin
        if (eof_s) state_s = RUN;
        else       state_s = WAIT_SOF;
      end
      RUN:     state_s = RUN;
      default: state_s = WAIT_SOF;
    endcase
  end

  // Clamp requested origin so the picture stays fully inside the active area
  always_comb begin
    if (bus.cfg_x > X_MAX) cap_x_s = X_MAX;
    else                   cap_x_s = bus.cfg_x;
    if (bus.cfg_y > Y_MAX) cap_y_s = Y_MAX;
    else                   cap_y_s = bus.cfg_y;
  end

  // Pending origin capture and apply at frame boundary
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      org_x_r  <= 10'd0;
      org_y_r  <= 10'd0;
      pend_x_r <= 10'd0;
      pend_y_r <= 10'd0;
      pend_r   <= 1'b0;
    end else if (eof_s && pend_r) begin
      org_x_r <= pend_x_r;
      org_y_r <= pend_y_r;
      pend_r  <= 1'b0;
    end else if (xfer_s) begin
      pend_x_r <= cap_x_s;
      pend_y_r <= cap_y_s;
      pend_r   <= 1'b1;
    end else begin
      pend_r <= pend_r;
    end
  end

  // ROM address: cleared each frame, saturates at the last picture word
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                              rom_addr_r <= 14'd0;
    else if (eof_s)                              rom_addr_r <= 14'd0;
    else if (hit_s && (rom_addr_r != ADDR_LAST)) rom_addr_r <= rom_addr_r + 14'd1;
    else                                         rom_addr_r <= rom_addr_r;
  end

  // Delay flags aligning pixel source selection with the one-cycle ROM latency
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hit_d_r <= 1'b0;
      act_d_r <= 1'b0;
    end else begin
      hit_d_r <= hit_s;
      act_d_r <= active_s;
    end
  end

  // Completed-frame counter
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  frame_cnt_r <= 8'd0;
    else if (eof_s)  frame_cnt_r <= frame_cnt_r + 8'd1;
    else             frame_cnt_r <= frame_cnt_r;
  end

  // Output pixel source select
  always_comb begin
    if (hit_d_r)      pix_data = bus.rom_data;
    else if (act_d_r) pix_data = BG_COLOR;
    else              pix_data = 16'h0000;
  end

endmodule

// File: tb/tb_vga_pic_sched.sv
// Randomised bench for vga_pic_sched on a small raster, checked every cycle against a geometric model.
module tb_vga_pic_sched;

  localparam logic [9:0]  HV = 10'd12;
  localparam logic [9:0]  VV = 10'd8;
  localparam logic [9:0]  PW = 10'd4;
  localparam logic [9:0]  PH = 10'd3;
  localparam logic [15:0] BG = 16'hFFFF;
  localparam int HVI = 12, VVI = 8, PWI = 4, PHI = 3;
  localparam int HT = 14, VT = 9, FR = HT * VT;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [9:0]  pix_x = 10'h3FF;
  logic [9:0]  pix_y = 10'h3FF;
  logic [15:0] pix_data;
  logic [7:0]  frame_cnt;

  vga_pic_sched_if bus();

  vga_pic_sched #(.H_VALID(HV), .V_VALID(VV), .PIC_W(PW), .PIC_H(PH), .BG_COLOR(BG)) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .bus(bus.slave), .pix_data(pix_data), .frame_cnt(frame_cnt)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [15:0] rom_f(input int a);
    logic [31:0] t;
    t = a * 32'd40503 + 32'd4660;
    return t[15:0] ^ t[31:16];
  endfunction

  always @(posedge vga_clk) if (bus.rom_rd_en) bus.rom_data <= rom_f(int'(bus.rom_addr));

  int n_chk = 0, n_fail = 0;
  bit m_run, m_pend, p_hit, p_act;
  int m_ox, m_oy, m_qx, m_qy, m_fc, p_addr;
  int tx, ty, mode;
  bit pin_f1, pin_f2;
  int hits, last_addr, first_hx, first_hy, first_ha, bg_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_pend = 1'b0; p_hit = 1'b0; p_act = 1'b0;
    m_ox = 0; m_oy = 0; m_qx = 0; m_qy = 0; m_fc = 0; p_addr = 0;
  endtask

  task automatic clr_stats();
    hits = 0; last_addr = -1; first_hx = -1; first_hy = -1; first_ha = -1; bg_cnt = 0;
  endtask

  task automatic set_pix();
    if (tx < HVI && ty < VVI) begin
      pix_x = 10'(tx); pix_y = 10'(ty);
    end else begin
      pix_x = 10'h3FF; pix_y = 10'h3FF;
    end
  endtask

  task automatic tick_pix();
    tx++;
    if (tx == HT) begin
      tx = 0; ty++;
      if (ty == VT) ty = 0;
    end
    set_pix();
  endtask

  task automatic offer(input logic [9:0] x, input logic [9:0] y);
    bus.cfg_valid = 1'b1; bus.cfg_x = x; bus.cfg_y = y;
  endtask

  // Called just before a rising edge with inputs stable; returns at the next falling edge.
  task automatic step();
    int px, py, addr;
    bit act, hit, eof, xfer;
    logic [15:0] exp_pix;
    px = int'(pix_x); py = int'(pix_y);
    act = (pix_x != 10'h3FF) && (pix_y != 10'h3FF);
    hit = m_run && act && px >= m_ox && px < m_ox + PWI && py >= m_oy && py < m_oy + PHI;
    addr = (py - m_oy) * PWI + (px - m_ox);
    eof = act && px == HVI - 1 && py == VVI - 1;
    if (p_hit)      exp_pix = rom_f(p_addr);
    else if (p_act) exp_pix = BG;
    else            exp_pix = 16'h0000;
    chk("rom_rd_en", 32'(bus.rom_rd_en), 32'(hit));
    chk("cfg_ready", 32'(bus.cfg_ready), 32'(!m_pend));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
    chk("pix_data", 32'(pix_data), 32'(exp_pix));
    if (hit) chk("rom_addr", 32'(bus.rom_addr), 32'(addr));
    if (bus.rom_rd_en) begin
      hits++;
      last_addr = int'(bus.rom_addr);
      if (first_hx < 0) begin
        first_hx = px; first_hy = py; first_ha = int'(bus.rom_addr);
      end
      if (pin_f2 && px == 3 && py == 0) chk("addr_x3_y0", 32'(bus.rom_addr), 32'd3);
      if (pin_f2 && px == 0 && py == 1) chk("addr_x0_y1", 32'(bus.rom_addr), 32'd4);
    end
    if (pin_f1 && pix_data == BG) bg_cnt++;
    xfer = 1'b0;
    if (eof) begin
      m_fc = (m_fc + 1) % 256;
      m_run = 1'b1;
    end
    if (eof && m_pend) begin
      m_ox = m_qx; m_oy = m_qy; m_pend = 1'b0;
    end else if (bus.cfg_valid && !m_pend) begin
      m_pend = 1'b1;
      m_qx = (int'(bus.cfg_x) > HVI - PWI) ? HVI - PWI : int'(bus.cfg_x);
      m_qy = (int'(bus.cfg_y) > VVI - PHI) ? VVI - PHI : int'(bus.cfg_y);
      xfer = 1'b1;
    end
    p_hit = hit; p_act = act; p_addr = addr;
    @(posedge vga_clk);
    #1;
    if (xfer) bus.cfg_valid = 1'b0;
    tick_pix();
    if (mode == 1 && !bus.cfg_valid &&
        ($urandom_range(0, 40) == 0 || (tx == HVI - 1 && ty == VVI - 1 && $urandom_range(0, 1) == 0)))
      offer(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    @(negedge vga_clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_first(input string name, input int x, input int y);
    chk({name, "_x"}, 32'(first_hx), 32'(x));
    chk({name, "_y"}, 32'(first_hy), 32'(y));
    chk({name, "_a"}, 32'(first_ha), 32'd0);
  endtask

  initial begin
    int w;
    bus.cfg_valid = 1'b0; bus.cfg_x = 10'd0; bus.cfg_y = 10'd0;
    mode = 0; pin_f1 = 1'b0; pin_f2 = 1'b0; tx = 0; ty = 0;
    model_reset();
    clr_stats();
    repeat (3) @(negedge vga_clk);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("rst_rd_en", 32'(bus.rom_rd_en), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    sys_rst_n = 1'b1;
    set_pix();
    #1;

    // frame 1: picture suppressed, background on every active pixel
    clr_stats(); pin_f1 = 1'b1; run(FR); pin_f1 = 1'b0;
    chk("f1_hits", 32'(hits), 32'd0);
    chk("f1_bg_pixels", 32'(bg_cnt), 32'd96);
    chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);

    // frame 2: picture at (0,0)
    clr_stats(); pin_f2 = 1'b1; run(FR); pin_f2 = 1'b0;
    chk("f2_hits", 32'(hits), 32'd12);
    chk("f2_last_addr", 32'(last_addr), 32'd11);
    chk_first("f2_first", 0, 0);

    // frame 3: clamped request mid-frame, second request held off
    clr_stats(); run(20);
    offer(10'd600, 10'd450); run(1);
    chk("clamp_x", 32'(m_qx), 32'd8);
    chk("clamp_y", 32'(m_qy), 32'd5);
    chk("f3_ready_low", 32'(bus.cfg_ready), 32'd0);
    offer(10'd1, 10'd2); run(5);
    chk("f3_second_held", 32'(bus.cfg_ready), 32'd0);
    run(FR - 26);
    chk_first("f3_first", 0, 0);

    clr_stats(); run(FR);
    chk_first("f4_first", 8, 5);
    chk("f4_hits", 32'(hits), 32'd12);

    // frame 5: transfer coinciding with eof while nothing pending
    clr_stats(); run(109);
    chk_first("f5_first", 1, 2);
    offer(10'd3, 10'd4); run(1);
    chk("f5_coinc_pend", 32'(bus.cfg_ready), 32'd0);
    run(FR - 110);
    clr_stats(); run(FR);
    chk_first("f6_first", 1, 2);
    clr_stats(); run(FR);
    chk_first("f7_first", 3, 4);

    mode = 1; run(30 * FR); mode = 0;

    // reset inside the picture window, far enough ahead of eof
    w = 0;
    while (!(bus.rom_rd_en && int'(pix_y) < VVI - 1) && w < 3 * FR) begin
      step(); w++;
    end
    chk("reset_wait_hit", 32'(bus.rom_rd_en), 32'd1);
    sys_rst_n = 1'b0; bus.cfg_valid = 1'b0;
    #1;
    chk("arst_pix_data", 32'(pix_data), 32'd0);
    chk("arst_rd_en", 32'(bus.rom_rd_en), 32'd0);
    chk("arst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge vga_clk); #1; tick_pix(); @(negedge vga_clk);
      chk("rst_hold_pix", 32'(pix_data), 32'd0);
    end
    sys_rst_n = 1'b1;
    model_reset();
    clr_stats();
    #1;
    w = 0;
    while (!(tx == 0 && ty == 0) && w < FR) begin
      step(); w++;
    end
    chk("post_rst_hits", 32'(hits), 32'd0);
    chk("post_rst_fc", 32'(frame_cnt), 32'd1);
    clr_stats(); run(FR);
    chk_first("post_rst_first", 0, 0);
    chk("post_rst_fc2", 32'(frame_cnt), 32'd2);
    run(254 * FR);
    chk("fc_wrap", 32'(frame_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pic_sched.md
VGA_PIC_SCHED -- requirements
Module: vga_pic_sched

Interface
Parameters:
REQ-001 The block SHALL have parameter H_VALID, default 10'd640, active pixels per line.
REQ-002 The block SHALL have parameter V_VALID, default 10'd480, active lines per frame.
REQ-003 The block SHALL have parameter PIC_W, default 10'd100, picture width in pixels.
REQ-004 The block SHALL have parameter PIC_H, default 10'd100, picture height in lines.
REQ-005 The block SHALL have parameter BG_COLOR, default 16'hFFFF, RGB565 colour outside the picture window.

Ports:
REQ-006 The block SHALL have port vga_clk, input, 1 bit, pixel clock.
REQ-007 The block SHALL have port sys_rst_n, input, 1 bit, reset: asynchronous, active-low.
REQ-008 The block SHALL have port pix_x, input, 10 bits, active column from the timing generator; 10'h3FF when blanking.
REQ-009 The block SHALL have port pix_y, input, 10 bits, active row from the timing generator; 10'h3FF when blanking.
REQ-010 The block SHALL have port cfg_valid, input, 1 bit, new picture origin offered.
REQ-011 The block SHALL have port cfg_x, input, 10 bits, requested origin column.
REQ-012 The block SHALL have port cfg_y, input, 10 bits, requested origin row.
REQ-013 The block SHALL have port cfg_ready, output, 1 bit, origin request can be accepted.
REQ-014 The block SHALL have port rom_rd_en, output, 1 bit, picture ROM read strobe.
REQ-015 The block SHALL have port rom_addr, output, 14 bits, picture ROM address.
REQ-016 The block SHALL have port rom_data, input, 16 bits, ROM read data, valid exactly one cycle after rom_rd_en.
REQ-017 The block SHALL have port pix_data, output, 16 bits, pixel colour to the timing generator.
REQ-018 The block SHALL have port frame_cnt, output, 8 bits, count of completed frames.

Function
REQ-019 Definitions: active = (pix_x != 10'h3FF) && (pix_y != 10'h3FF); eof = active && pix_x == H_VALID-1 && pix_y == V_VALID-1.
REQ-020 The FSM SHALL have states WAIT_SOF and RUN; it SHALL reset to WAIT_SOF.
REQ-021 In WAIT_SOF, eof SHALL move the FSM to RUN in the next cycle; no other event SHALL leave WAIT_SOF.
REQ-022 RUN SHALL persist until reset.
REQ-023 Window hit = state==RUN && active && org_x <= pix_x < org_x+PIC_W && org_y <= pix_y < org_y+PIC_H, using 11-bit compares with no wrap.
REQ-024 rom_rd_en SHALL equal hit, combinationally.
REQ-025 rom_addr SHALL be a register that increments by 1 after each cycle with rom_rd_en=1.
REQ-026 rom_addr SHALL be cleared to 0 on eof; eof has priority over increment.
REQ-027 rom_addr SHALL never exceed PIC_W*PIC_H-1; on reaching that value it SHALL hold until eof.
REQ-028 pix_data SHALL have 1-cycle latency and SHALL be driven from registered flags hit_d and act_d.
REQ-029 pix_data SHALL be rom_data if hit_d, else BG_COLOR if act_d, else 16'h0000.
REQ-030 Config handshake: a transfer occurs when cfg_valid && cfg_ready; on transfer, cfg_x and cfg_y SHALL be captured into a pending register and pend SHALL be set.
REQ-031 cfg_ready SHALL equal !pend; a second request SHALL stall until the pending one is applied.
REQ-032 Clamping: the captured x SHALL be min(cfg_x, H_VALID-PIC_W).
REQ-033 Clamping: the captured y SHALL be min(cfg_y, V_VALID-PIC_H).
REQ-034 Apply: on eof with pend=1, org_x and org_y SHALL load from the pending register and pend SHALL clear in the same cycle; the origin SHALL never change mid-frame.
REQ-035 When eof and a transfer coincide with pend=0, the new values SHALL be captured into pending and applied at the next eof, not the current one.
REQ-036 frame_cnt SHALL increment on every eof, in both states, and wrap 8'hFF->8'h00.

Reset
REQ-037 Asynchronous assertion of reset SHALL set: state=WAIT_SOF, org_x=0, org_y=0, pend=0, rom_addr=0, hit_d=0, act_d=0, frame_cnt=0.
REQ-038 During reset, outputs SHALL be: cfg_ready=1, rom_rd_en=0, pix_data=16'h0000.
REQ-039 Reset mid-frame SHALL discard any pending origin; after release, the picture SHALL be suppressed (BG_COLOR on active pixels) until the first eof.
REQ-040 Release of reset SHALL be synchronous to vga_clk.

Verification
REQ-041 Reset, then one full frame -> rom_rd_en=0 throughout; active pixels show 16'hFFFF; frame_cnt=1 after eof.
REQ-042 Origin (0,0), second frame -> first hit at pix=(0,0) with rom_addr=0; pixel (99,0) reads rom_addr=99; pixel (0,1) reads rom_addr=100; last read at rom_addr=9999; pix_data equals rom_data one cycle after each read.
REQ-043 cfg (600,450) offered mid-frame -> captured as (540,380); cfg_ready=0 until eof; window moves only in the next frame.
REQ-044 Second cfg offered while pend=1 -> held off (cfg_ready=0); accepted in the cycle after eof; applied one frame later.
REQ-045 Transfer in the same cycle as eof with pend=0 -> origin unchanged for the next frame; new origin applied the frame after.
REQ-046 Reset asserted mid-window -> pix_data=0 immediately; after release, one frame of BG_COLOR, then picture at origin (0,0); frame_cnt restarts from 0 and wraps after 256 frames.
